// File: rtl/and_4.sv
// and_4: four-input AND with a registered copy, a rising-edge pulse and a saturating hit counter.
// Define AND4_HITCNT_EN to build the hit counter; otherwise hit_cnt is tied to 0 and clr is ignored.
module and_4 #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   output logic             y,
   output logic             y_q,
   output logic             y_rise,
   input  logic             clr,
   output logic [CNT_W-1:0] hit_cnt
);

   assign y = a & b & c & d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q    <= 1'b0;
         y_rise <= 1'b0;
      end else begin
         y_q    <= y;
         y_rise <= y & ~y_q;
      end
   end

`ifdef AND4_HITCNT_EN
   // clr wins over a same-edge hit; the counter sticks at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt <= '0;
      end else if (clr) begin
         hit_cnt <= '0;
      end else if (y && (hit_cnt != '1)) begin
         hit_cnt <= hit_cnt + 1'b1;
      end
   end
`else
   logic clr_unused;

   assign clr_unused = clr;
   assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_and_4.sv
// Bench for and_4: directed test-plan scenarios plus randomized cycles checked against a behavioural model.
module tb_and_4;

   localparam int unsigned CNT_W = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef AND4_HITCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             a, b, c, d;
   logic             clr;
   logic             y, y_q, y_rise;
   logic [CNT_W-1:0] hit_cnt;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_yq   = 0;
   int m_rise = 0;
   int m_cnt  = 0;

   and_4 #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .y       (y),
      .y_q     (y_q),
      .y_rise  (y_rise),
      .clr     (clr),
      .hit_cnt (hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_y();
      return ((int'(a) + int'(b) + int'(c) + int'(d)) == 4) ? 1 : 0;
   endfunction

   task automatic set_in(input logic [3:0] v);
      {a, b, c, d} = v;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".y"},      {31'd0, y},      ref_y());
      check({tag, ".y_q"},    {31'd0, y_q},    m_yq);
      check({tag, ".y_rise"}, {31'd0, y_rise}, m_rise);
      check({tag, ".hit"},    {28'd0, hit_cnt}, m_cnt);
   endtask

   // one clock: model update at the edge, check 1 unit later, return at the falling edge
   task automatic tick(input string tag);
      int cy;
      @(posedge clk);
      cy = ref_y();
      if (rst_n === 1'b1) begin
         m_rise = (cy == 1 && m_yq == 0) ? 1 : 0;
         m_yq   = cy;
         if (CNT_ON) begin
            if (clr === 1'b1)                m_cnt = 0;
            else if (cy == 1 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         end
      end
      #1;
      check_regs(tag);
      @(negedge clk);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      m_yq = 0; m_rise = 0; m_cnt = 0;
      check_regs(tag);
      @(negedge clk);
      tick(tag);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      set_in(4'b1111);
      #1;
      check_regs("reset_hold");

      // truth table while held in reset
      for (int i = 0; i < 16; i++) begin
         logic [3:0] v;
         v = i[3:0];
         set_in(v);
         #2;
         check("truth", {31'd0, y}, (i == 15) ? 1 : 0);
         #8;
      end

      @(negedge clk);
      set_in(4'b1111);
      tick("reset_in_hold");
      rst_n = 1'b1;
      tick("release1");
      check("release_rise", {31'd0, y_rise}, 1);
      tick("release2");
      check("release_rise_once", {31'd0, y_rise}, 0);

      // edge pulse: 1111 -> 0111 -> 1111 with y held high in between
      for (int k = 0; k < 3; k++) begin
         set_in(4'b0111);
         tick("edge_low");
         set_in(4'b1111);
         tick("edge_high");
         tick("edge_hold1");
         tick("edge_hold2");
      end

      // saturation
      clr = 1'b1;
      tick("sat_clr");
      clr = 1'b0;
      for (int k = 0; k < 20; k++) tick("sat");
      check("sat_final", {28'd0, hit_cnt}, CNT_ON ? CNT_MAX : 0);

      // reset mid-operation from a saturated counter
      async_reset("mid_reset");

      // clear priority at count 5
      clr = 1'b1;
      tick("clr0");
      clr = 1'b0;
      for (int k = 0; k < 5; k++) tick("cnt_to5");
      check("cnt5", {28'd0, hit_cnt}, CNT_ON ? 5 : 0);
      clr = 1'b1;
      tick("clr_prio");
      check("clr_prio_zero", {28'd0, hit_cnt}, 0);
      clr = 1'b0;
      for (int k = 0; k < 3; k++) tick("cnt_to3");
      check("cnt3", {28'd0, hit_cnt}, CNT_ON ? 3 : 0);

      // randomized traffic, inputs biased toward 1 so hits are frequent
      for (int n = 0; n < 400; n++) begin
         logic [3:0] v;
         for (int j = 0; j < 4; j++) v[j] = ($urandom_range(0, 3) != 0);
         set_in(v);
         clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 59) == 0) async_reset("rand_reset");
         else tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
